act_rr_arbiter: RTL and testbench

//  Shares one leaky_relu activation unit between NUM_REQ producer channels (PE column outputs).

---
 rtl/act_rr_arbiter.sv | 142 ++++++++++++++
 tb/tb_act_rr_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_rr_arbiter.sv
// Round-robin arbiter that shares one activation unit between NUM_REQ producers.
// A tag pipe matched to the unit latency routes each result back to its owner.
module act_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int LAT     = 1,
  parameter int BURST   = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         act_in_data,
  output logic                      act_in_valid,
  input  logic [DATA_W-1:0]         act_out_data,
  input  logic                      act_out_valid,
  output logic [DATA_W-1:0]         res_data,
  output logic [NUM_REQ-1:0]        res_valid,
  output logic [ID_W-1:0]           grant_id,
  output logic                      idle,
  output logic                      err
);

  localparam int BW = $clog2(BURST) + 1;

  typedef enum logic {IDLE, SERVE} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] cur, cur_nxt, ptr, ptr_nxt, cur_inc, act_in_id;
  logic [BW-1:0]   beats, beats_nxt;
  logic            beat;
  logic [ID_W:0]   pick_ptr, pick_next;
  logic [LAT-1:0]  tag_v;
  logic [ID_W-1:0] tag_id [LAT];

  // Returns {found, index} of the first set bit in v scanning base, base+1, ... with wrap.
  function automatic logic [ID_W:0] pick_from(input logic [NUM_REQ-1:0] v,
                                              input logic [ID_W-1:0]    base);
    logic [ID_W:0] r;
    int unsigned   idx;
    r = '0;
    for (int unsigned k = NUM_REQ; k > 0; k--) begin
      idx = 32'(base) + k - 1;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (v[idx[ID_W-1:0]]) r = {1'b1, idx[ID_W-1:0]};
    end
    return r;
  endfunction

  always_comb begin
    req_ready = '0;
    if (state == SERVE && en) req_ready[cur] = 1'b1;
  end

  assign beat      = req_valid[cur] & req_ready[cur];
  assign cur_inc   = (cur == ID_W'(NUM_REQ - 1)) ? '0 : cur + 1'b1;
  assign pick_ptr  = pick_from(req_valid, ptr);
  assign pick_next = pick_from(req_valid, cur_inc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cur   <= '0;
      ptr   <= '0;
      beats <= '0;
    end else begin
      state <= state_nxt;
      cur   <= cur_nxt;
      ptr   <= ptr_nxt;
      beats <= beats_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    ptr_nxt   = ptr;
    beats_nxt = beats;
    unique case (state)
      IDLE: begin
        if (en && pick_ptr[ID_W]) begin
          state_nxt = SERVE;
          cur_nxt   = pick_ptr[ID_W-1:0];
          beats_nxt = '0;
        end
      end
      SERVE: begin
        if (!en) begin
          state_nxt = IDLE;
          ptr_nxt   = cur_inc;
          beats_nxt = '0;
        end else if (!req_valid[cur] || (beat && beats == BW'(BURST - 1))) begin
          // Burst end or bubble: hand over on the same edge, cur is searched last.
          beats_nxt = '0;
          ptr_nxt   = cur_inc;
          if (pick_next[ID_W]) cur_nxt = pick_next[ID_W-1:0];
          else                 state_nxt = IDLE;
        end else if (beat) begin
          beats_nxt = beats + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_in_data  <= '0;
      act_in_valid <= 1'b0;
      act_in_id    <= '0;
      tag_v        <= '0;
      for (int unsigned i = 0; i < LAT; i++) tag_id[i] <= '0;
      res_data     <= '0;
      res_valid    <= '0;
      err          <= 1'b0;
    end else begin
      act_in_valid <= beat;
      if (beat) begin
        act_in_data <= req_data[cur*DATA_W +: DATA_W];
        act_in_id   <= cur;
      end
      tag_v[0]  <= act_in_valid;
      tag_id[0] <= act_in_id;
      for (int unsigned i = 1; i < LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
      res_valid <= '0;
      if (act_out_valid && tag_v[LAT-1]) begin
        res_data  <= act_out_data;
        res_valid <= NUM_REQ'(1) << tag_id[LAT-1];
      end
      if (act_out_valid != tag_v[LAT-1]) err <= 1'b1;
    end
  end

  assign grant_id = cur;
  assign idle     = (state == IDLE) & ~act_in_valid & ~|tag_v & ~|res_valid;

endmodule

// File: tb/tb_act_rr_arbiter.sv
// Bench for act_rr_arbiter: leaky-ReLU unit model (A=1/4, LAT=1) plus a behavioural
// round-robin reference model; directed scenarios followed by a random phase.
module tb_act_rr_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int LAT     = 1;
  localparam int BURST   = 4;
  localparam int ID_W    = 2;

  logic                      clk = 1'b0;
  logic                      rst, en;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         act_in_data, act_out_data, res_data;
  logic                      act_in_valid, act_out_valid;
  logic [NUM_REQ-1:0]        res_valid;
  logic [ID_W-1:0]           grant_id;
  logic                      idle, err;

  logic                      unit_v, force_ov;
  logic [DATA_W-1:0]         unit_d;

  always #5 clk = ~clk;

  act_rr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .LAT(LAT), .BURST(BURST), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .act_in_data(act_in_data), .act_in_valid(act_in_valid),
    .act_out_data(act_out_data), .act_out_valid(act_out_valid), .res_data(res_data),
    .res_valid(res_valid), .grant_id(grant_id), .idle(idle), .err(err)
  );

  function automatic logic [7:0] lrelu(input logic [7:0] x);
    int v;
    v = int'($signed(x));
    if (v < 0) v = (v - 3) / 4;  // floor division by 4
    return 8'(v);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      unit_v <= 1'b0;
      unit_d <= '0;
    end else begin
      unit_v <= act_in_valid;
      unit_d <= lrelu(act_in_data);
    end
  end
  assign act_out_valid = unit_v | force_ov;
  assign act_out_data  = unit_d;

  int n_cmp = 0, n_bad = 0;

  // reference model state
  int         m_srv, m_own, m_ptr, m_cnt, m_acc, m_err;
  int         m_ain_v, m_ain_id, m_mid_v, m_mid_id;
  logic [7:0] m_ain_d, m_mid_d, m_res_d;
  logic [3:0] m_res_v;

  logic [7:0] src [NUM_REQ][$];
  bit         hold [NUM_REQ];
  logic [7:0] obs_ain[$], obs_res[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int base);
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (base + k) % NUM_REQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_srv = 0; m_own = 0; m_ptr = 0; m_cnt = 0; m_acc = -1; m_err = 0;
    m_ain_v = 0; m_ain_id = 0; m_ain_d = '0;
    m_mid_v = 0; m_mid_id = 0; m_mid_d = '0;
    m_res_v = '0; m_res_d = '0;
  endtask

  task automatic check_all();
    logic [3:0] er;
    er = (m_srv != 0 && en) ? 4'(1 << m_own) : 4'h0;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("act_in_valid", 32'(act_in_valid), 32'(m_ain_v));
    chk("act_in_data", 32'(act_in_data), 32'(m_ain_d));
    chk("res_valid", 32'(res_valid), 32'(m_res_v));
    chk("res_data", 32'(res_data), 32'(m_res_d));
    chk("grant_id", 32'(grant_id), 32'(m_own));
    chk("err", 32'(err), 32'(m_err));
    chk("idle", 32'(idle), 32'(m_srv == 0 && m_ain_v == 0 && m_mid_v == 0 && m_res_v == 0));
    if (res_valid != 0) obs_res.push_back(res_data);
    if (act_in_valid) obs_ain.push_back(act_in_data);
  endtask

  task automatic model_step();
    int aov, acc, p;
    acc   = (m_srv != 0 && en && req_valid[m_own]) ? 1 : 0;
    m_acc = acc ? m_own : -1;
    aov   = (m_mid_v != 0 || force_ov) ? 1 : 0;
    if (aov != m_mid_v) m_err = 1;
    if (aov != 0 && m_mid_v != 0) begin
      m_res_v = 4'(1 << m_mid_id);
      m_res_d = m_mid_d;
    end else m_res_v = '0;
    m_mid_v = m_ain_v; m_mid_id = m_ain_id; m_mid_d = lrelu(m_ain_d);
    m_ain_v = acc;
    if (acc != 0) begin
      m_ain_d  = req_data[m_own*DATA_W +: DATA_W];
      m_ain_id = m_own;
    end
    if (m_srv == 0) begin
      if (en && req_valid != 0) begin m_srv = 1; m_own = pick(req_valid, m_ptr); m_cnt = 0; end
    end else if (!en) begin
      m_srv = 0; m_ptr = (m_own + 1) % NUM_REQ; m_cnt = 0;
    end else if (!req_valid[m_own] || m_cnt == BURST - 1) begin
      m_cnt = 0; m_ptr = (m_own + 1) % NUM_REQ;
      p = pick(req_valid, m_ptr);
      if (p < 0) m_srv = 0; else m_own = p;
    end else m_cnt++;
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (hold[i]) begin
        req_valid[i] = 1'b1;
        req_data[i*DATA_W +: DATA_W] = 8'($urandom);
      end else begin
        req_valid[i] = (src[i].size() > 0);
        req_data[i*DATA_W +: DATA_W] = (src[i].size() > 0) ? src[i][0] : 8'h00;
      end
    end
  endtask

  // one clock: inputs at posedge+1, check at negedge, model advances across posedge
  task automatic tick();
    drive();
    @(negedge clk);
    check_all();
    model_step();
    if (m_acc >= 0 && !hold[m_acc]) void'(src[m_acc].pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int start, total;
    logic [7:0] exp4 [4];
    rst = 1'b0; en = 1'b0; force_ov = 1'b0;
    req_valid = '0; req_data = '0;
    for (int i = 0; i < NUM_REQ; i++) hold[i] = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk); #1;
    check_all();
    rst = 1'b1;

    // single requester, burst of four signed samples
    en = 1'b1;
    src[0] = '{8'd16, 8'd24, 8'hF0, 8'hE8};
    obs_ain.delete(); obs_res.delete();
    repeat (10) tick();
    exp4 = '{8'd16, 8'd24, 8'hF0, 8'hE8};
    chk("t1_ain_count", 32'(obs_ain.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("t1_ain", (i < obs_ain.size()) ? 32'(obs_ain[i]) : 32'hFFFF_FFFF, 32'(exp4[i]));
    exp4 = '{8'd16, 8'd24, 8'hFC, 8'hFA};
    chk("t1_res_count", 32'(obs_res.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("t1_res", (i < obs_res.size()) ? 32'(obs_res[i]) : 32'hFFFF_FFFF, 32'(exp4[i]));

    // all requesters held valid: owners rotate every BURST beats with no gap
    for (int i = 0; i < NUM_REQ; i++) hold[i] = 1'b1;
    start = m_ptr;
    tick();
    for (int k = 0; k < 4 * BURST; k++) begin
      chk("t2_rr_grant", 32'(grant_id), 32'((start + k / BURST) % NUM_REQ));
      chk("t2_ready_nz", 32'(req_ready != 0), 32'd1);
      tick();
    end
    for (int i = 0; i < NUM_REQ; i++) hold[i] = 1'b0;
    en = 1'b0;
    repeat (4) tick();

    // requester 1 runs dry after one beat, requester 2 takes over after a bubble
    do_reset();
    en = 1'b1;
    src[1] = '{8'h11};
    src[2] = '{8'h33, 8'h44, 8'h55};
    obs_ain.delete();
    repeat (10) tick();
    exp4 = '{8'h11, 8'h33, 8'h44, 8'h55};
    chk("t3_ain_count", 32'(obs_ain.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("t3_ain", (i < obs_ain.size()) ? 32'(obs_ain[i]) : 32'hFFFF_FFFF, 32'(exp4[i]));

    // enable dropped mid-burst with two samples in flight
    src[0] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    repeat (3) tick();
    en = 1'b0;
    obs_res.delete();
    repeat (6) tick();
    chk("t4_drained", 32'(obs_res.size()), 32'd2);
    chk("t4_idle", 32'(idle), 32'd1);
    src[0].delete();

    // reset with samples in flight
    en = 1'b1;
    src[0] = '{8'd7, 8'd8, 8'd9, 8'd10};
    repeat (3) tick();
    do_reset();
    src[0].delete();
    obs_res.delete();
    repeat (5) tick();
    chk("t5_no_res", 32'(obs_res.size()), 32'd0);

    // spurious act_out_valid with an empty tag pipe
    force_ov = 1'b1;
    tick();
    force_ov = 1'b0;
    repeat (3) tick();
    chk("t6_err_sticky", 32'(err), 32'd1);
    chk("t6_no_res", 32'(obs_res.size()), 32'd0);

    // random traffic
    do_reset();
    for (int c = 0; c < 400; c++) begin
      en = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < NUM_REQ; i++)
        if ($urandom_range(0, 3) == 0 && src[i].size() < 6) src[i].push_back(8'($urandom));
      tick();
    end
    en = 1'b1;
    for (int c = 0; c < 200; c++) begin
      total = 0;
      for (int i = 0; i < NUM_REQ; i++) total += src[i].size();
      if (total == 0) break;
      tick();
    end
    total = 0;
    for (int i = 0; i < NUM_REQ; i++) total += src[i].size();
    chk("rand_drain", 32'(total), 32'd0);
    repeat (5) tick();
    chk("rand_idle", 32'(idle), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
